// File: rtl/tick_divider_pkg.sv
// Shared constants and helpers for the multi-channel tick/clock divider.
package tick_divider_pkg;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned DIV_1HZ_100M    = 50_000_000;
    localparam int unsigned DIV_100HZ_100M  = 500_000;
    localparam int unsigned DEFAULT_DIV_DEF = DIV_1HZ_100M;

    // Channel-select width; a single-channel build still needs one select bit.
    function automatic int unsigned ch_sel_w(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/tick_divider_multi_if.sv
// Control/status bundle between the stopwatch control logic and the divider.
interface tick_divider_multi_if
    import tick_divider_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    localparam int unsigned CH_W = ch_sel_w(N_CH);

    logic              enable;
    logic              sync;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_data;
    logic [N_CH-1:0]   tick_out;
    logic [N_CH-1:0]   clock_out;

    modport master (
        output enable, sync, div_wr, div_ch, div_data,
        input  tick_out, clock_out
    );

    modport slave (
        input  enable, sync, div_wr, div_ch, div_data,
        output tick_out, clock_out
    );

endinterface

// File: rtl/tick_divider_ch.sv
// One divider channel: counter, active/shadow divisor, tick strobe and toggle output.
module tick_divider_ch
    import tick_divider_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] div_data,
    output logic             tick_out,
    output logic             clock_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;

    // Every shadow load sees a same-cycle write, so sync and idle pick it up at once.
    always_comb begin
        shd_d  = wr ? div_data : shd_q;
        act_d  = act_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        clk_d  = clk_q;
        if (sync) begin
            act_d = shd_d;
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (act_q == '0) begin
            act_d = shd_d;
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == act_q - CNT_W'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                clk_d  = ~clk_q;
                act_d  = shd_d;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q  <= '0;
            act_q  <= DIV_RST;
            shd_q  <= DIV_RST;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
        end
    end

    assign tick_out  = tick_q;
    assign clock_out = clk_q;

endmodule

// File: rtl/tick_divider_multi.sv
// N_CH independent programmable dividers sharing global enable and phase sync.
module tick_divider_multi
    import tick_divider_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                 clock_in,
    input  logic                 reset,
    tick_divider_multi_if.slave  bus
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic wr_c;

        // Out-of-range channel numbers match no channel and are dropped.
        always_comb wr_c = bus.div_wr && (32'(bus.div_ch) == 32'(g));

        tick_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_in  (clock_in),
            .reset     (reset),
            .enable    (bus.enable),
            .sync      (bus.sync),
            .wr        (wr_c),
            .div_data  (bus.div_data),
            .tick_out  (bus.tick_out[g]),
            .clock_out (bus.clock_out[g])
        );
    end

endmodule

// File: tb/tb_tick_divider_multi.sv
// Scoreboard bench: directed stimulus pushes hand-derived per-edge expectations, a monitor checks them.
module tb_tick_divider_multi;
    import tick_divider_pkg::*;

    typedef struct {
        int unsigned at;
        int unsigned dut;
        int unsigned ch;
        logic        tick;
        logic        ck;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        init_rst;
    logic        done;
    int unsigned edge_n;
    int          checks;
    int          errors;
    exp_t        sb_q[$];

    tick_divider_multi_if #(.N_CH(4), .CNT_W(32)) b1 ();
    tick_divider_multi_if #(.N_CH(3), .CNT_W(32)) b2 ();

    tick_divider_multi #(.N_CH(4), .CNT_W(32), .DEFAULT_DIV(5)) u_dut1 (
        .clock_in (clk),
        .reset    (rst),
        .bus      (b1.slave)
    );

    tick_divider_multi #(.N_CH(3), .CNT_W(32), .DEFAULT_DIV(5)) u_dut2 (
        .clock_in (clk),
        .reset    (rst),
        .bus      (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge 1 is the first rising edge after the initial reset is released.
    always @(posedge clk) edge_n <= init_rst ? 32'd0 : edge_n + 32'd1;

    // Expected pattern over [from,to]: ticks every `period` edges from `first`; period 0 = flat.
    task automatic push_win(input int unsigned d, input int unsigned ch,
                            input int unsigned from, input int unsigned to,
                            input int unsigned first, input int unsigned period,
                            input logic ck0);
        logic c;
        logic t;
        c = ck0;
        for (int unsigned e = from; e <= to; e++) begin
            t = (period != 0) && (e >= first) && (((e - first) % period) == 0);
            if (t) c = ~c;
            sb_q.push_back('{at: e, dut: d, ch: ch, tick: t, ck: c});
        end
    endtask

    task automatic push_all(input int unsigned d, input int unsigned nch,
                            input int unsigned from, input int unsigned to,
                            input int unsigned first, input int unsigned period,
                            input logic ck0);
        for (int unsigned c = 0; c < nch; c++) push_win(d, c, from, to, first, period, ck0);
    endtask

    task automatic at_edge(input int unsigned k);
        while (edge_n < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due at the current edge, flag any left behind.
    always @(negedge clk) begin
        logic a_t;
        logic a_c;
        for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
            if (sb_q[i].at < edge_n) begin
                errors++;
                $display("FAIL stale d%0d ch%0d edge %0d never checked", sb_q[i].dut, sb_q[i].ch, sb_q[i].at);
                sb_q.delete(i);
            end else if (sb_q[i].at == edge_n) begin
                if (sb_q[i].dut == 1) begin
                    a_t = b1.tick_out[sb_q[i].ch];
                    a_c = b1.clock_out[sb_q[i].ch];
                end else begin
                    a_t = b2.tick_out[sb_q[i].ch];
                    a_c = b2.clock_out[sb_q[i].ch];
                end
                checks++;
                if ({a_t, a_c} !== {sb_q[i].tick, sb_q[i].ck}) begin
                    errors++;
                    $display("FAIL d%0d ch%0d edge %0d tick/clock got %b/%b want %b/%b",
                             sb_q[i].dut, sb_q[i].ch, edge_n, a_t, a_c, sb_q[i].tick, sb_q[i].ck);
                end
                sb_q.delete(i);
            end
        end
        if (done) begin
            foreach (sb_q[i]) begin
                errors++;
                $display("FAIL pending d%0d ch%0d edge %0d unchecked", sb_q[i].dut, sb_q[i].ch, sb_q[i].at);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        done        = 1'b0;
        edge_n      = 0;
        rst         = 1'b1;
        init_rst    = 1'b1;
        b1.enable   = 1'b1;  b1.sync = 1'b0;  b1.div_wr = 1'b0;  b1.div_ch = 2'd0;  b1.div_data = 32'd0;
        b2.enable   = 1'b1;  b2.sync = 1'b0;  b2.div_wr = 1'b0;  b2.div_ch = 2'd0;  b2.div_data = 32'd0;

        // Reset state, then free-running D=5 on every channel.
        push_all(1, 4, 0, 0, 0, 0, 1'b0);
        push_all(2, 3, 0, 0, 0, 0, 1'b0);
        push_win(1, 0, 1, 52, 5, 5, 1'b0);
        push_win(1, 3, 1, 52, 5, 5, 1'b0);
        push_win(1, 1, 1, 19, 5, 5, 1'b0);
        push_win(1, 2, 1, 35, 5, 5, 1'b0);
        push_all(2, 3, 1, 83, 5, 5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        init_rst = 1'b0;

        // ch1 <- 3 mid-period: finishes the 5-cycle period at 20, then every 3.
        at_edge(16);
        b1.div_wr = 1'b1;  b1.div_ch = 2'd1;  b1.div_data = 32'd3;
        push_win(1, 1, 20, 52, 20, 3, 1'b1);
        at_edge(17);
        b1.div_wr = 1'b0;

        // ch2 <- 0: goes idle after its wrap at 35 with clock_out frozen high.
        at_edge(31);
        b1.div_wr = 1'b1;  b1.div_ch = 2'd2;  b1.div_data = 32'd0;
        push_win(1, 2, 36, 40, 0, 0, 1'b1);
        at_edge(32);
        b1.div_wr = 1'b0;

        // ch2 <- 2 while idle: first tick two edges after the write edge.
        at_edge(39);
        b1.div_wr = 1'b1;  b1.div_ch = 2'd2;  b1.div_data = 32'd2;
        push_win(1, 2, 41, 52, 42, 2, 1'b1);
        at_edge(40);
        b1.div_wr = 1'b0;

        // Pause for 7 edges with ch0 at cnt=2: everything frozen, no ticks.
        at_edge(52);
        b1.enable = 1'b0;
        push_win(1, 0, 53, 59, 0, 0, 1'b0);
        push_win(1, 1, 53, 59, 0, 0, 1'b0);
        push_win(1, 2, 53, 59, 0, 0, 1'b1);
        push_win(1, 3, 53, 59, 0, 0, 1'b0);
        at_edge(59);
        b1.enable = 1'b1;
        push_win(1, 0, 60, 71, 62, 5, 1'b0);
        push_win(1, 3, 60, 71, 62, 5, 1'b0);
        push_win(1, 1, 60, 71, 60, 3, 1'b0);
        push_win(1, 2, 60, 71, 61, 2, 1'b1);

        // sync on ch0/ch3 wrap edge with ch0 <- 4: no tick, all clocks low, ch0 ticks 4 later.
        at_edge(71);
        b1.sync   = 1'b1;
        b1.div_wr = 1'b1;  b1.div_ch = 2'd0;  b1.div_data = 32'd4;
        push_all(1, 4, 72, 72, 0, 0, 1'b0);
        push_win(1, 0, 73, 83, 76, 4, 1'b0);
        push_win(1, 1, 73, 83, 75, 3, 1'b0);
        push_win(1, 2, 73, 83, 74, 2, 1'b0);
        push_win(1, 3, 73, 83, 77, 5, 1'b0);
        at_edge(72);
        b1.sync   = 1'b0;
        b1.div_wr = 1'b0;

        // Reset mid-count: outputs clear and every divisor returns to 5.
        at_edge(83);
        rst = 1'b1;
        push_all(1, 4, 84, 84, 0, 0, 1'b0);
        push_all(2, 3, 84, 84, 0, 0, 1'b0);
        push_all(1, 4, 85, 100, 89, 5, 1'b0);
        push_win(2, 1, 85, 100, 89, 5, 1'b0);
        push_win(2, 2, 85, 100, 89, 5, 1'b0);
        push_win(2, 0, 85, 89, 89, 5, 1'b0);
        push_win(2, 0, 90, 100, 0, 0, 1'b1);
        at_edge(84);
        rst = 1'b0;

        // 3-channel build: div_ch=N_CH is dropped; a long divisor on ch0 applies only after its wrap.
        at_edge(85);
        b2.div_wr = 1'b1;  b2.div_ch = 2'd3;  b2.div_data = 32'd2;
        at_edge(86);
        b2.div_ch = 2'd0;  b2.div_data = DIV_100HZ_100M;
        at_edge(87);
        b2.div_wr = 1'b0;

        // sync with ch3 <- 1: ch3 ticks every cycle and toggles at clock_in/2.
        at_edge(100);
        b1.sync   = 1'b1;
        b1.div_wr = 1'b1;  b1.div_ch = 2'd3;  b1.div_data = 32'd1;
        push_all(1, 4, 101, 101, 0, 0, 1'b0);
        push_win(1, 0, 102, 108, 106, 5, 1'b0);
        push_win(1, 1, 102, 108, 106, 5, 1'b0);
        push_win(1, 2, 102, 108, 106, 5, 1'b0);
        push_win(1, 3, 102, 108, 102, 1, 1'b0);
        at_edge(101);
        b1.sync   = 1'b0;
        b1.div_wr = 1'b0;

        at_edge(110);
        done = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL monitor did not close the run");
        $fatal(1);
    end

endmodule
